// File: rtl/axis_buf_arbiter_pkg.sv
// Shared parameters and state encodings for the two-requester AXI-Stream
// buffer arbiter.
package axis_buf_arbiter_pkg;

  localparam int DEF_DWIDTH  = 16;
  localparam int DEF_BUFSIZE = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_XFER = ST_XFER,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/axis_buf_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any,
  output logic       pick
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    any  = |req;
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/axis_buf_arbiter.sv
// Grants one of two stream requesters a whole packet at a time, forwards its
// beats into a shared buffer and reports each packet's beat count.
module axis_buf_arbiter
  import axis_buf_arbiter_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int BUFSIZE = DEF_BUFSIZE
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              s0_tvalid,
  input  logic [DWIDTH-1:0] s0_tdata,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic              s1_tvalid,
  input  logic [DWIDTH-1:0] s1_tdata,
  input  logic              s1_tlast,
  output logic              s1_tready,
  input  logic              buf_isfull,
  output logic              buf_we,
  output logic [DWIDTH-1:0] buf_wdata,
  output logic              buf_wsrc,
  output logic              pkt_done,
  output logic [BUFSIZE:0]  pkt_len
);

  localparam logic [BUFSIZE:0] CNT_MAX = (BUFSIZE + 1)'(1) << BUFSIZE;

  state_t           state, state_nx;
  logic             grant, grant_nx;
  logic             last_grant, last_nx;
  logic [BUFSIZE:0] count, count_nx;

  logic             req_any, req_pick;
  logic             g_valid, g_last, g_ready;
  logic [DWIDTH-1:0] g_data;
  logic             xfer;

  rr_arbiter2 u_rr (
    .req        ({s1_tvalid, s0_tvalid}),
    .last_grant (last_grant),
    .any        (req_any),
    .pick       (req_pick)
  );

  assign xfer    = (state == S_XFER);
  assign g_valid = grant ? s1_tvalid : s0_tvalid;
  assign g_last  = grant ? s1_tlast  : s0_tlast;
  assign g_data  = grant ? s1_tdata  : s0_tdata;
  assign g_ready = xfer && !buf_isfull;

  assign s0_tready = g_ready && (grant == 1'b0);
  assign s1_tready = g_ready && (grant == 1'b1);
  assign buf_we    = g_valid && g_ready;
  // Data is gated outside S_XFER so the buffer port is quiet while idle or in reset.
  assign buf_wdata = xfer ? g_data : '0;
  assign buf_wsrc  = grant;
  assign pkt_done  = (state == S_DONE);
  assign pkt_len   = (state == S_DONE) ? count : '0;

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last_grant;
    count_nx = count;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          grant_nx = req_pick;
          state_nx = S_XFER;
        end
      end
      S_XFER: begin
        if (buf_we) begin
          if (count != CNT_MAX) count_nx = count + 1'b1;
          if (g_last) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        last_nx  = grant;
        count_nx = '0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    if (xrst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_nx;
      count      <= count_nx;
    end
  end

endmodule

// File: tb/tb_axis_buf_arbiter.sv
// Directed bench for axis_buf_arbiter: single packets, alternation, stalls,
// mid-packet reset and length saturation.
module tb_axis_buf_arbiter;

  localparam int DW = 16;
  localparam int BS = 4;

  logic          clk = 1'b0;
  logic          xrst;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic [DW-1:0] s0_tdata, s1_tdata;
  logic          buf_isfull, buf_we, buf_wsrc, pkt_done;
  logic [DW-1:0] buf_wdata;
  logic [BS:0]   pkt_len;

  typedef struct {
    bit            src;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  len_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  viol     = 0;
  int  cyc      = 0;
  int  last_wr_cyc = 0;
  int  done_cyc    = 0;

  axis_buf_arbiter #(.DWIDTH(DW), .BUFSIZE(BS)) dut (
    .clk        (clk),
    .xrst       (xrst),
    .s0_tvalid  (s0_tvalid),
    .s0_tdata   (s0_tdata),
    .s0_tlast   (s0_tlast),
    .s0_tready  (s0_tready),
    .s1_tvalid  (s1_tvalid),
    .s1_tdata   (s1_tdata),
    .s1_tlast   (s1_tlast),
    .s1_tready  (s1_tready),
    .buf_isfull (buf_isfull),
    .buf_we     (buf_we),
    .buf_wdata  (buf_wdata),
    .buf_wsrc   (buf_wsrc),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observes the buffer port away from the rising edge.
  always @(negedge clk) begin
    if (!xrst) begin
      if (buf_we) begin
        wr_q.push_back('{buf_wsrc, buf_wdata});
        last_wr_cyc = cyc;
      end
      if (pkt_done) begin
        len_q.push_back(int'(pkt_len));
        done_cyc = cyc;
      end
      if ((s0_tready && buf_wsrc) || (s1_tready && !buf_wsrc) ||
          (s0_tready && s1_tready) || (buf_isfull && buf_we))
        viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_src(input bit src, input bit v, input logic [DW-1:0] d, input bit l);
    if (src) begin
      s1_tvalid = v; s1_tdata = d; s1_tlast = l;
    end else begin
      s0_tvalid = v; s0_tdata = d; s0_tlast = l;
    end
  endtask

  task automatic src_send(input bit src, input int n, input logic [DW-1:0] base, input bit last_en);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int guard;
      set_src(src, 1'b1, DW'(base + i), last_en && (i == n - 1));
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = src ? s1_tready : s0_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        check("handshake_timeout", 64'd0, 64'd1);
        break;
      end
    end
    set_src(src, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    xrst = 1'b1;
    s0_tvalid = 0; s0_tdata = '0; s0_tlast = 0;
    s1_tvalid = 0; s1_tdata = '0; s1_tlast = 0;
    buf_isfull = 0;
    repeat (2) @(posedge clk);
    #1;
    wr_q.delete();
    len_q.delete();
    viol = 0;
    xrst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input bit src, input logic [DW-1:0] base, input int n);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {47'd0, wr_q[i].src, wr_q[i].data},
            {47'd0, src, DW'(base + i)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs held at zero during reset even with a requester active.
    xrst = 1'b1;
    s0_tvalid = 1; s0_tdata = 16'hBEEF; s0_tlast = 1;
    s1_tvalid = 1; s1_tdata = 16'hCAFE; s1_tlast = 1;
    buf_isfull = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {s0_tready, s1_tready, buf_we, buf_wsrc, pkt_done, pkt_len, buf_wdata}, 64'd0);

    // Four-beat packet from s0 with one cycle of grant latency.
    do_reset();
    set_src(0, 1'b1, 16'h0100, 1'b0);
    @(negedge clk);
    check("grant_latency", 64'(s0_tready), 64'd0);
    @(posedge clk);
    #1;
    src_send(0, 4, 16'h0100, 1'b1);
    idle(3);
    check_writes("s0_4beat", 1'b0, 16'h0100, 4);
    check("s0_4beat_ndone", 64'(len_q.size()), 64'd1);
    if (len_q.size() > 0) check("s0_4beat_len", 64'(len_q[0]), 64'd4);

    // Both requesters continuously valid: packets alternate s0, s1, s0, s1.
    do_reset();
    fork
      begin
        src_send(0, 3, 16'h0100, 1'b1);
        src_send(0, 3, 16'h0200, 1'b1);
      end
      begin
        src_send(1, 3, 16'h1100, 1'b1);
        src_send(1, 3, 16'h1200, 1'b1);
      end
    join
    idle(3);
    check("alt_nwr", 64'(wr_q.size()), 64'd12);
    for (int k = 0; k < 12 && k < wr_q.size(); k++) begin
      bit            es;
      logic [DW-1:0] ed;
      es = 1'((k / 3) % 2);
      ed = (es ? 16'h1100 : 16'h0100) + DW'((k / 6) * 16'h0100) + DW'(k % 3);
      check($sformatf("alt_wr%0d", k), {47'd0, wr_q[k].src, wr_q[k].data}, {47'd0, es, ed});
    end
    check("alt_ndone", 64'(len_q.size()), 64'd4);
    check("alt_ready_excl", 64'(viol), 64'd0);

    // s1 packet stalled by a full buffer for three cycles after beat 2.
    do_reset();
    fork
      src_send(1, 5, 16'h3000, 1'b1);
      begin
        int guard = 0;
        while (wr_q.size() < 2 && guard < 200) begin
          @(posedge clk);
          guard++;
        end
        #1;
        buf_isfull = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        buf_isfull = 1'b0;
      end
    join
    idle(3);
    check_writes("stall", 1'b1, 16'h3000, 5);
    if (len_q.size() > 0) check("stall_len", 64'(len_q[0]), 64'd5);
    else check("stall_len", 64'd0, 64'd5);
    check("stall_no_we", 64'(viol), 64'd0);

    // Single-beat packet.
    do_reset();
    src_send(0, 1, 16'h0777, 1'b1);
    idle(3);
    check_writes("single", 1'b0, 16'h0777, 1);
    if (len_q.size() > 0) check("single_len", 64'(len_q[0]), 64'd1);
    else check("single_len", 64'd0, 64'd1);
    check("single_done_gap", 64'(done_cyc - last_wr_cyc), 64'd1);

    // Reset two beats into a six-beat packet.
    do_reset();
    src_send(0, 2, 16'h0500, 1'b0);
    set_src(0, 1'b1, 16'h0502, 1'b0);
    xrst = 1'b1;
    #1;
    check("midrst_outputs",
          {s0_tready, s1_tready, buf_we, buf_wsrc, pkt_done, pkt_len, buf_wdata}, 64'd0);
    check_writes("midrst_pre", 1'b0, 16'h0500, 2);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(len_q.size()), 64'd0);
    wr_q.delete();
    s1_tvalid = 1'b1;
    xrst = 1'b0;
    fork
      src_send(0, 1, 16'h0A00, 1'b1);
      src_send(1, 1, 16'h1A00, 1'b1);
    join
    idle(3);
    check("midrst_nwr", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() >= 2) begin
      check("midrst_tie_first", {47'd0, wr_q[0].src, wr_q[0].data}, {47'd0, 1'b0, 16'h0A00});
      check("midrst_tie_second", {47'd0, wr_q[1].src, wr_q[1].data}, {47'd0, 1'b1, 16'h1A00});
    end

    // Packet longer than the buffer depth: length saturates at 16.
    do_reset();
    src_send(1, 19, 16'h4000, 1'b1);
    idle(3);
    check_writes("sat", 1'b1, 16'h4000, 19);
    if (len_q.size() > 0) check("sat_len", 64'(len_q[0]), 64'd16);
    else check("sat_len", 64'd0, 64'd16);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
